kf8237_transfer_sequencer: RTL and testbench
============================================

Name: kf8237_transfer_sequencer

Overview:
- Timing-and-control stage directly downstream of the 8237 priority encoder.
- Consumes the one-hot `encoded_dma` winner and runs the HRQ/HLDA handshake and the S0–S4 DMA bus-cycle state machine.
- Drives DACK, EOP, and the memory/IO strobes.
- Returns `dma_acknowledge_internal`, `end_of_process_internal`, `dma_rotate` and `edge_request` to the encoder, and a `next_word` pulse to the address/count block.

Parameters:
- None. Channel count is fixed at 4.

Ports:
- `clock` input 1: system clock.
- `reset` input 1: asynchronous reset, active-low (asserted at 0).
- `cpu_clock_posedge` input 1: one-`clock` enable marking a DMA clock rising edge.
- `cpu_clock_negedge` input 1: one-`clock` enable marking a DMA clock falling edge.
- `master_clear` input 1: software reset pulse.
- `encoded_dma` input 4: one-hot winning channel, or 0 when there is no request.
- `dma_request_state` input 4: qualified requests, used for demand-mode hold-off.
- `transfer_mode` input 8: 2 bits per channel, bits [2n+1:2n]: 00 demand, 01 single, 10 block, 11 cascade.
- `transfer_type` input 8: 2 bits per channel: 00 verify, 01 write (IO→mem), 10 read (mem→IO), 11 illegal (treated as verify).
- `dack_sense_active_high` input 1: DACK output polarity.
- `terminal_count` input 1: count block reports that the current word is the last one.
- `end_of_process_n` input 1: external EOP, active-low.
- `ready` input 1: wait-state request, sampled in S3.
- `hold_acknowledge` input 1: HLDA from the bus arbiter.
- `hold_request` output 1: HRQ.
- `dma_acknowledge` output 4: external DACK, polarity applied.
- `dma_acknowledge_internal` output 4: active-high DACK for the encoder.
- `end_of_process_internal` output 1: one-`clock` pulse.
- `end_of_process_n_out` output 1: EOP drive, active-low.
- `dma_rotate` output 2: index of the last-serviced channel.
- `edge_request` output 4: 1 for channels in single/block mode.
- `address_enable` output 1: AEN.
- `next_word` output 1: one-`clock` pulse to advance address and count.
- `memory_read_n`, `memory_write_n`, `io_read_n`, `io_write_n` outputs 1 each: bus strobes.

Behaviour:
- **Reset** (`reset`=0, async) or `master_clear`:
  - state goes to SI; `hold_request`=0; `dma_acknowledge_internal`=0; all strobes=1; `address_enable`=0.
  - `dma_rotate`=2'b11, so channel 0 has highest priority after the first rotate.
  - `next_word`=0; `end_of_process_internal`=0; `end_of_process_n_out`=1.
  - `dma_acknowledge` = `~dack_sense_active_high` on all bits.
- **Clocking:** all state transitions happen only on `clock` cycles where `cpu_clock_posedge`=1. Strobe deassertion and the S4 outputs update on `cpu_clock_negedge`.
- **SI:**
  - If `encoded_dma`≠0, latch the channel index into `active_ch` and go to S0.
  - `hold_request` rises on the same clock.
- **S0:**
  - Hold HRQ.
  - If `hold_acknowledge`=1, go to S1. Otherwise stay.
  - If `encoded_dma` drops to 0 before HLDA, return to SI and drop HRQ.
- **Cascade mode:**
  - In S1, assert DACK for `active_ch` and go to SC.
  - SC stays while `encoded_dma[active_ch]`=1 and no strobes are driven. It then returns to SI.
- **S1:** `address_enable`=1; go to S2.
- **S2:**
  - Assert DACK for `active_ch`.
  - Read transfer: `memory_read_n`=0.
  - Write transfer: `io_read_n`=0.
  - Go to S3.
- **S3:**
  - Read transfer: `io_write_n`=0.
  - Write transfer: `memory_write_n`=0.
  - Verify: no strobes.
  - If `ready`=0, stay in S3 (wait states, no limit).
  - Otherwise go to S4.
- **S4:**
  - On `cpu_clock_negedge`: release all strobes and pulse `next_word` for one `clock`.
  - EOP condition = `terminal_count`=1 OR `end_of_process_n`=0 sampled in S4.
  - On EOP: pulse `end_of_process_internal`, drive `end_of_process_n_out`=0 for this S4 only, and terminate.
- **After S4, by mode:**
  - Single: terminate.
  - Block: go to S1 unless EOP.
  - Demand: go to S1 if `dma_request_state[active_ch]`=1, otherwise terminate.
- **Terminate:**
  - Drop DACK, `address_enable` and HRQ.
  - Set `dma_rotate` = `active_ch`.
  - Go to SI.
  - HRQ stays low for at least one SI cycle before a new request is accepted.
- **`dma_acknowledge_internal`:** one-hot at `active_ch` from S2 through S4 (from S1 in cascade). Zero elsewhere.
- **Simultaneous EOP and demand deassert:** EOP wins; `end_of_process_internal` pulses.
- **`master_clear` mid-transfer:** immediate return to the reset values; no EOP pulse.
- **HLDA dropping during S1–S4:** ignored. HLDA is only checked in S0.

Decomposition:
- Extend the shared package with:
  - a state enum (SI, S0, S1, S2, S3, S4, SC);
  - transfer-mode constants (DEMAND, SINGLE, BLOCK, CASCADE);
  - transfer-type constants (VERIFY, WRITE, READ).
- No sub-module: the FSM and the output decode stay in one file.

Test Plan:
- **Single read, ch2:** `encoded_dma`=0100, HLDA after 2 cycles → S0→S1→S2→S3→S4→SI.
  - `memory_read_n` low S2–S4, `io_write_n` low S3–S4.
  - One `next_word` pulse; `dma_rotate`=2; HRQ drops.
- **Block write, ch0, `terminal_count` on the 3rd S4:**
  - Three S1–S4 loops and three `next_word` pulses.
  - `end_of_process_internal` pulses once; `end_of_process_n_out` low during the 3rd S4 only.
- **Demand, ch1:** `dma_request_state[1]` cleared after the 2nd word → exactly 2 transfers, no EOP.
- **Wait states:** `ready`=0 for 3 DMA clocks in S3 → S3 is held for 3 extra cycles and the strobes stay asserted.
- **Cascade, ch3:** HLDA given → DACK3 asserted, no strobes, AEN=0; clearing `encoded_dma` → return to SI.
- **Reset and clear mid-transfer:**
  - `reset`=0 in S3 → all outputs take their reset values asynchronously, with DACK polarity following `dack_sense_active_high`.
  - Same check for `master_clear`, which acts on the next `clock`.

Source files
------------

// File: rtl/kf8237_transfer_sequencer_pkg.sv
// Shared types and helpers for the 8237 transfer sequencer.
package kf8237_transfer_sequencer_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  // DMA bus-cycle states; SC is the cascade pass-through state
  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5,
    SC = 3'd6
  } state_t;

  // Per-channel transfer mode field
  typedef enum logic [1:0] {
    DEMAND  = 2'b00,
    SINGLE  = 2'b01,
    BLOCK   = 2'b10,
    CASCADE = 2'b11
  } mode_t;

  // Per-channel transfer type field; ILLEGAL behaves as VERIFY
  typedef enum logic [1:0] {
    VERIFY  = 2'b00,
    WRITE   = 2'b01,
    READ    = 2'b10,
    ILLEGAL = 2'b11
  } xfer_t;

  // Active-low bus strobes
  typedef struct packed {
    logic memory_read_n;
    logic memory_write_n;
    logic io_read_n;
    logic io_write_n;
  } strobe_t;

  localparam strobe_t STROBES_IDLE = strobe_t'(4'b1111);

  // Index of the set bit of a one-hot channel vector (0 when empty)
  function automatic logic [CH_W-1:0] onehot_to_index(input logic [NUM_CH-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // One-hot vector for a channel index
  function automatic logic [NUM_CH-1:0] index_to_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/kf8237_transfer_sequencer.sv
// 8237 timing and control: HRQ/HLDA handshake, S0-S4 bus cycles, DACK/EOP/strobes.
module kf8237_transfer_sequencer
  import kf8237_transfer_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_clock_posedge,
  input  logic              cpu_clock_negedge,
  input  logic              master_clear,
  input  logic [NUM_CH-1:0] encoded_dma,
  input  logic [NUM_CH-1:0] dma_request_state,
  input  logic [7:0]        transfer_mode,
  input  logic [7:0]        transfer_type,
  input  logic              dack_sense_active_high,
  input  logic              terminal_count,
  input  logic              end_of_process_n,
  input  logic              ready,
  input  logic              hold_acknowledge,
  output logic              hold_request,
  output logic [NUM_CH-1:0] dma_acknowledge,
  output logic [NUM_CH-1:0] dma_acknowledge_internal,
  output logic              end_of_process_internal,
  output logic              end_of_process_n_out,
  output logic [CH_W-1:0]   dma_rotate,
  output logic [NUM_CH-1:0] edge_request,
  output logic              address_enable,
  output logic              next_word,
  output logic              memory_read_n,
  output logic              memory_write_n,
  output logic              io_read_n,
  output logic              io_write_n
);

  state_t            state;
  state_t            state_next;
  logic [CH_W-1:0]   active_ch;
  logic [CH_W-1:0]   active_ch_next;
  mode_t             cur_mode;
  xfer_t             cur_type;
  logic              eop_cond;

  strobe_t           strobe_q;
  strobe_t           strobe_d;
  logic              hrq_d;
  logic              aen_d;
  logic              next_word_d;
  logic              eop_int_d;
  logic              eop_n_d;
  logic [NUM_CH-1:0] dack_int_d;
  logic [NUM_CH-1:0] edge_d;
  logic [CH_W-1:0]   rotate_d;

  // Mode/type fields of the channel being serviced
  assign cur_mode = mode_t'(transfer_mode[{active_ch, 1'b0} +: 2]);
  assign cur_type = xfer_t'(transfer_type[{active_ch, 1'b0} +: 2]);
  assign eop_cond = terminal_count | ~end_of_process_n;

  // External DACK follows the live polarity input so it is correct even while in reset
  assign dma_acknowledge = dma_acknowledge_internal ^ {NUM_CH{~dack_sense_active_high}};

  assign memory_read_n  = strobe_q.memory_read_n;
  assign memory_write_n = strobe_q.memory_write_n;
  assign io_read_n      = strobe_q.io_read_n;
  assign io_write_n     = strobe_q.io_write_n;

  // State register and latched channel
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= SI;
      active_ch <= '0;
    end else if (master_clear) begin
      state     <= SI;
      active_ch <= '0;
    end else begin
      state     <= state_next;
      active_ch <= active_ch_next;
    end
  end

  // Next-state logic; transitions only on DMA clock rising edges
  always_comb begin
    state_next     = state;
    active_ch_next = active_ch;
    if (cpu_clock_posedge) begin
      case (state)
        SI: begin
          if (encoded_dma != '0) begin
            state_next     = S0;
            active_ch_next = onehot_to_index(encoded_dma);
          end
        end
        S0: begin
          if (encoded_dma == '0)    state_next = SI;
          else if (hold_acknowledge) state_next = S1;
        end
        S1: state_next = (cur_mode == CASCADE) ? SC : S2;
        S2: state_next = S3;
        S3: if (ready) state_next = S4;
        S4: begin
          // EOP was captured into end_of_process_n_out at the S4 falling edge
          if (!end_of_process_n_out) begin
            state_next = SI;
          end else begin
            case (cur_mode)
              BLOCK:   state_next = S1;
              DEMAND:  state_next = dma_request_state[active_ch] ? S1 : SI;
              default: state_next = SI;
            endcase
          end
        end
        SC: if (!encoded_dma[active_ch]) state_next = SI;
        default: state_next = SI;
      endcase
    end
  end

  // Output decode: next values of every registered output
  always_comb begin
    hrq_d       = hold_request;
    aen_d       = address_enable;
    dack_int_d  = dma_acknowledge_internal;
    strobe_d    = strobe_q;
    rotate_d    = dma_rotate;
    eop_n_d     = end_of_process_n_out;
    next_word_d = 1'b0;
    eop_int_d   = 1'b0;
    // Single and block modes differ in their two mode bits
    edge_d      = {transfer_mode[7] ^ transfer_mode[6],
                   transfer_mode[5] ^ transfer_mode[4],
                   transfer_mode[3] ^ transfer_mode[2],
                   transfer_mode[1] ^ transfer_mode[0]};

    if (cpu_clock_posedge) begin
      hrq_d      = (state_next != SI);
      eop_n_d    = 1'b1;
      aen_d      = 1'b0;
      dack_int_d = '0;
      case (state_next)
        S1: begin
          if (cur_mode == CASCADE) dack_int_d = index_to_onehot(active_ch_next);
          else                     aen_d      = 1'b1;
        end
        S2, S3, S4: begin
          aen_d      = 1'b1;
          dack_int_d = index_to_onehot(active_ch_next);
        end
        SC:      dack_int_d = index_to_onehot(active_ch_next);
        default: ;
      endcase

      // Source strobe opens the transfer in S2, destination strobe follows in S3
      case (state_next)
        S2: begin
          if (state == S1) begin
            strobe_d.memory_read_n = (cur_type != READ);
            strobe_d.io_read_n     = (cur_type != WRITE);
          end
        end
        S3: begin
          if (state == S2) begin
            strobe_d.io_write_n     = (cur_type != READ);
            strobe_d.memory_write_n = (cur_type != WRITE);
          end
        end
        S4:      ;
        default: strobe_d = STROBES_IDLE;
      endcase

      // Terminating a transfer moves the rotate pointer to the serviced channel
      if ((state_next == SI) && ((state == S4) || (state == SC))) begin
        rotate_d = active_ch;
      end
    end

    // S4 falling edge: release strobes, advance the word, report EOP
    if (cpu_clock_negedge && (state == S4)) begin
      strobe_d    = STROBES_IDLE;
      next_word_d = 1'b1;
      eop_int_d   = eop_cond;
      eop_n_d     = ~eop_cond;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_request             <= 1'b0;
      address_enable           <= 1'b0;
      dma_acknowledge_internal <= '0;
      strobe_q                 <= STROBES_IDLE;
      dma_rotate               <= 2'b11;
      end_of_process_n_out     <= 1'b1;
      next_word                <= 1'b0;
      end_of_process_internal  <= 1'b0;
      edge_request             <= '0;
    end else if (master_clear) begin
      hold_request             <= 1'b0;
      address_enable           <= 1'b0;
      dma_acknowledge_internal <= '0;
      strobe_q                 <= STROBES_IDLE;
      dma_rotate               <= 2'b11;
      end_of_process_n_out     <= 1'b1;
      next_word                <= 1'b0;
      end_of_process_internal  <= 1'b0;
      edge_request             <= edge_d;
    end else begin
      hold_request             <= hrq_d;
      address_enable           <= aen_d;
      dma_acknowledge_internal <= dack_int_d;
      strobe_q                 <= strobe_d;
      dma_rotate               <= rotate_d;
      end_of_process_n_out     <= eop_n_d;
      next_word                <= next_word_d;
      end_of_process_internal  <= eop_int_d;
      edge_request             <= edge_d;
    end
  end

endmodule

// File: tb/tb_kf8237_transfer_sequencer.sv
// Directed self-checking bench for kf8237_transfer_sequencer.
module tb_kf8237_transfer_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_clock_posedge;
  logic       cpu_clock_negedge;
  logic       master_clear;
  logic [3:0] encoded_dma;
  logic [3:0] dma_request_state;
  logic [7:0] transfer_mode;
  logic [7:0] transfer_type;
  logic       dack_sense_active_high;
  logic       terminal_count;
  logic       end_of_process_n;
  logic       ready;
  logic       hold_acknowledge;
  logic       hold_request;
  logic [3:0] dma_acknowledge;
  logic [3:0] dma_acknowledge_internal;
  logic       end_of_process_internal;
  logic       end_of_process_n_out;
  logic [1:0] dma_rotate;
  logic [3:0] edge_request;
  logic       address_enable;
  logic       next_word;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       io_read_n;
  logic       io_write_n;

  int total = 0;
  int bad   = 0;
  logic [12:0] got;
  logic [12:0] exp;

  kf8237_transfer_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .cpu_clock_posedge        (cpu_clock_posedge),
    .cpu_clock_negedge        (cpu_clock_negedge),
    .master_clear             (master_clear),
    .encoded_dma              (encoded_dma),
    .dma_request_state        (dma_request_state),
    .transfer_mode            (transfer_mode),
    .transfer_type            (transfer_type),
    .dack_sense_active_high   (dack_sense_active_high),
    .terminal_count           (terminal_count),
    .end_of_process_n         (end_of_process_n),
    .ready                    (ready),
    .hold_acknowledge         (hold_acknowledge),
    .hold_request             (hold_request),
    .dma_acknowledge          (dma_acknowledge),
    .dma_acknowledge_internal (dma_acknowledge_internal),
    .end_of_process_internal  (end_of_process_internal),
    .end_of_process_n_out     (end_of_process_n_out),
    .dma_rotate               (dma_rotate),
    .edge_request             (edge_request),
    .address_enable           (address_enable),
    .next_word                (next_word),
    .memory_read_n            (memory_read_n),
    .memory_write_n           (memory_write_n),
    .io_read_n                (io_read_n),
    .io_write_n               (io_write_n)
  );

  always #5 clock = ~clock;

  // DMA clock enables: one rising and one falling marker every 4 system clocks
  initial begin
    int phase;
    phase = 0;
    cpu_clock_posedge = 1'b0;
    cpu_clock_negedge = 1'b0;
    forever begin
      @(negedge clock);
      phase = (phase + 1) % 4;
      cpu_clock_posedge = (phase == 0);
      cpu_clock_negedge = (phase == 2);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {hrq, aen, dack_int[3:0], mrd_n, mwr_n, iord_n, iowr_n, next_word, eop_int, eop_n_out}
  function automatic logic [12:0] snap();
    return {hold_request, address_enable, dma_acknowledge_internal,
            memory_read_n, memory_write_n, io_read_n, io_write_n,
            next_word, end_of_process_internal, end_of_process_n_out};
  endfunction

  task automatic tick_pos();
    for (int n = 0; n < 8; n++) begin
      @(posedge clock);
      if (cpu_clock_posedge) break;
    end
    #1;
  endtask

  task automatic tick_neg();
    for (int n = 0; n < 8; n++) begin
      @(posedge clock);
      if (cpu_clock_negedge) break;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL rst_outputs: got %b want %b", got, exp); end
    total++;
    if (dma_rotate !== 2'b11) begin bad++; $display("FAIL rst_rotate: got %b want 11", dma_rotate); end
    total++;
    if (dma_acknowledge !== 4'b1111) begin bad++; $display("FAIL rst_dack: got %b want 1111", dma_acknowledge); end
    total++;
    if (edge_request !== 4'b0000) begin bad++; $display("FAIL rst_edge: got %b want 0000", edge_request); end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) tick_pos();
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL rst_idle: got %b want %b", got, exp); end
  endtask

  task automatic test_single_read();
    transfer_mode = 8'b00_01_00_00; transfer_type = 8'b00_10_00_00;
    encoded_dma = 4'b0100; hold_acknowledge = 1'b0;
    tick_pos();
    exp = 13'b1_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s0: got %b want %b", got, exp); end
    tick_pos();
    got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s0_hold: got %b want %b", got, exp); end
    hold_acknowledge = 1'b1;
    tick_pos();
    exp = 13'b1_1_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s1: got %b want %b", got, exp); end
    tick_pos();
    exp = 13'b1_1_0100_0111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s2: got %b want %b", got, exp); end
    total++;
    if (dma_acknowledge !== 4'b1011) begin bad++; $display("FAIL sr_dack_pol: got %b want 1011", dma_acknowledge); end
    tick_pos();
    exp = 13'b1_1_0100_0110_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s3: got %b want %b", got, exp); end
    tick_pos();
    got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s4: got %b want %b", got, exp); end
    encoded_dma = 4'b0000; hold_acknowledge = 1'b0;
    tick_neg();
    exp = 13'b1_1_0100_1111_1_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_s4_fall: got %b want %b", got, exp); end
    @(posedge clock); #1;
    exp = 13'b1_1_0100_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_nw_pulse: got %b want %b", got, exp); end
    tick_pos();
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL sr_done: got %b want %b", got, exp); end
    total++;
    if (dma_rotate !== 2'd2) begin bad++; $display("FAIL sr_rotate: got %0d want 2", dma_rotate); end
  endtask

  task automatic test_master_clear();
    transfer_mode = 8'b00_01_00_00; transfer_type = 8'b00_10_00_00;
    encoded_dma = 4'b0100; hold_acknowledge = 1'b1;
    repeat (4) tick_pos();
    exp = 13'b1_1_0100_0110_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL mc_s3: got %b want %b", got, exp); end
    master_clear = 1'b1;
    @(posedge clock); #1;
    master_clear = 1'b0; encoded_dma = 4'b0000; hold_acknowledge = 1'b0;
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL mc_clear: got %b want %b", got, exp); end
    total++;
    if (dma_rotate !== 2'b11) begin bad++; $display("FAIL mc_rotate: got %b want 11", dma_rotate); end
    total++;
    if (dma_acknowledge !== 4'b1111) begin bad++; $display("FAIL mc_dack: got %b want 1111", dma_acknowledge); end
    tick_neg();
    got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL mc_no_eop: got %b want %b", got, exp); end
  endtask

  task automatic test_block_write();
    transfer_mode = 8'b00_00_00_10; transfer_type = 8'b00_00_00_01;
    encoded_dma = 4'b0001; hold_acknowledge = 1'b1; terminal_count = 1'b0;
    tick_pos();
    tick_pos();
    exp = 13'b1_1_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL bw_s1: got %b want %b", got, exp); end
    for (int k = 1; k <= 3; k++) begin
      tick_pos();
      exp = 13'b1_1_0001_1101_0_0_1; got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL bw_s2[%0d]: got %b want %b", k, got, exp); end
      tick_pos();
      exp = 13'b1_1_0001_1001_0_0_1; got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL bw_s3[%0d]: got %b want %b", k, got, exp); end
      tick_pos();
      if (k == 3) begin terminal_count = 1'b1; encoded_dma = 4'b0000; end
      tick_neg();
      exp = (k == 3) ? 13'b1_1_0001_1111_1_1_0 : 13'b1_1_0001_1111_1_0_1;
      got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL bw_s4_fall[%0d]: got %b want %b", k, got, exp); end
      terminal_count = 1'b0;
      if (k == 3) begin
        @(posedge clock); #1;
        exp = 13'b1_1_0001_1111_0_0_0; got = snap(); total++;
        if (got !== exp) begin bad++; $display("FAIL bw_eop_pulse: got %b want %b", got, exp); end
      end
      tick_pos();
      exp = (k == 3) ? 13'b0_0_0000_1111_0_0_1 : 13'b1_1_0000_1111_0_0_1;
      got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL bw_after_s4[%0d]: got %b want %b", k, got, exp); end
    end
    hold_acknowledge = 1'b0;
    total++;
    if (dma_rotate !== 2'd0) begin bad++; $display("FAIL bw_rotate: got %0d want 0", dma_rotate); end
  endtask

  task automatic test_demand();
    transfer_mode = 8'b00_00_00_00; transfer_type = 8'b00_00_00_00;
    dma_request_state = 4'b0010; encoded_dma = 4'b0010; hold_acknowledge = 1'b1;
    tick_pos();
    tick_pos();
    for (int k = 1; k <= 2; k++) begin
      tick_pos();
      exp = 13'b1_1_0010_1111_0_0_1; got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL dm_s2[%0d]: got %b want %b", k, got, exp); end
      tick_pos();
      tick_pos();
      if (k == 2) begin dma_request_state = 4'b0000; encoded_dma = 4'b0000; end
      tick_neg();
      exp = 13'b1_1_0010_1111_1_0_1; got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL dm_s4_fall[%0d]: got %b want %b", k, got, exp); end
      tick_pos();
      exp = (k == 1) ? 13'b1_1_0000_1111_0_0_1 : 13'b0_0_0000_1111_0_0_1;
      got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL dm_after_s4[%0d]: got %b want %b", k, got, exp); end
    end
    total++;
    if (dma_rotate !== 2'd1) begin bad++; $display("FAIL dm_rotate: got %0d want 1", dma_rotate); end
  endtask

  task automatic test_demand_eop();
    dma_request_state = 4'b0010; encoded_dma = 4'b0010; hold_acknowledge = 1'b1;
    repeat (5) tick_pos();
    dma_request_state = 4'b0000; encoded_dma = 4'b0000; end_of_process_n = 1'b0;
    tick_neg();
    exp = 13'b1_1_0010_1111_1_1_0; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL de_s4_fall: got %b want %b", got, exp); end
    end_of_process_n = 1'b1;
    @(posedge clock); #1;
    exp = 13'b1_1_0010_1111_0_0_0; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL de_pulse: got %b want %b", got, exp); end
    tick_pos();
    hold_acknowledge = 1'b0;
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL de_done: got %b want %b", got, exp); end
  endtask

  task automatic test_async_reset();
    transfer_mode = 8'b00_01_00_00; transfer_type = 8'b00_10_00_00;
    encoded_dma = 4'b0100; hold_acknowledge = 1'b1;
    repeat (4) tick_pos();
    exp = 13'b1_1_0100_0110_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL ar_s3: got %b want %b", got, exp); end
    dack_sense_active_high = 1'b1;
    #1 reset = 1'b0;
    #1;
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL ar_outputs: got %b want %b", got, exp); end
    total++;
    if (dma_rotate !== 2'b11) begin bad++; $display("FAIL ar_rotate: got %b want 11", dma_rotate); end
    total++;
    if (dma_acknowledge !== 4'b0000) begin bad++; $display("FAIL ar_dack_hi: got %b want 0000", dma_acknowledge); end
    dack_sense_active_high = 1'b0;
    #1;
    total++;
    if (dma_acknowledge !== 4'b1111) begin bad++; $display("FAIL ar_dack_lo: got %b want 1111", dma_acknowledge); end
    encoded_dma = 4'b0000; hold_acknowledge = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_wait_states();
    dack_sense_active_high = 1'b1;
    transfer_mode = 8'b00_01_00_00; transfer_type = 8'b00_10_00_00;
    encoded_dma = 4'b0100; hold_acknowledge = 1'b1; ready = 1'b0;
    repeat (3) tick_pos();
    total++;
    if (dma_acknowledge !== 4'b0100) begin bad++; $display("FAIL ws_dack_pol: got %b want 0100", dma_acknowledge); end
    tick_pos();
    exp = 13'b1_1_0100_0110_0_0_1;
    for (int w = 1; w <= 3; w++) begin
      tick_neg();
      got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL ws_fall[%0d]: got %b want %b", w, got, exp); end
      tick_pos();
      got = snap(); total++;
      if (got !== exp) begin bad++; $display("FAIL ws_hold[%0d]: got %b want %b", w, got, exp); end
    end
    ready = 1'b1;
    tick_pos();
    encoded_dma = 4'b0000; hold_acknowledge = 1'b0;
    tick_neg();
    exp = 13'b1_1_0100_1111_1_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL ws_s4_fall: got %b want %b", got, exp); end
    tick_pos();
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL ws_done: got %b want %b", got, exp); end
    dack_sense_active_high = 1'b0;
  endtask

  task automatic test_cascade();
    transfer_mode = 8'b11_00_00_00; transfer_type = 8'b00_00_00_00;
    encoded_dma = 4'b1000; hold_acknowledge = 1'b1;
    tick_pos();
    exp = 13'b1_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL cs_s0: got %b want %b", got, exp); end
    tick_pos();
    exp = 13'b1_0_1000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL cs_s1: got %b want %b", got, exp); end
    tick_neg();
    got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL cs_s1_fall: got %b want %b", got, exp); end
    repeat (2) tick_pos();
    got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL cs_sc: got %b want %b", got, exp); end
    encoded_dma = 4'b0000; hold_acknowledge = 1'b0;
    tick_pos();
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL cs_done: got %b want %b", got, exp); end
    total++;
    if (dma_rotate !== 2'd3) begin bad++; $display("FAIL cs_rotate: got %0d want 3", dma_rotate); end
  endtask

  task automatic test_s0_abort();
    transfer_mode = 8'b00_00_00_00;
    encoded_dma = 4'b0001; hold_acknowledge = 1'b0;
    tick_pos();
    exp = 13'b1_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL ab_s0: got %b want %b", got, exp); end
    encoded_dma = 4'b0000;
    tick_pos();
    exp = 13'b0_0_0000_1111_0_0_1; got = snap(); total++;
    if (got !== exp) begin bad++; $display("FAIL ab_si: got %b want %b", got, exp); end
  endtask

  task automatic test_edge_request();
    transfer_mode = 8'b11_10_01_00;
    @(posedge clock); #1;
    total++;
    if (edge_request !== 4'b0110) begin bad++; $display("FAIL er_a: got %b want 0110", edge_request); end
    transfer_mode = 8'b01_00_10_11;
    @(posedge clock); #1;
    total++;
    if (edge_request !== 4'b1010) begin bad++; $display("FAIL er_b: got %b want 1010", edge_request); end
  endtask

  initial begin
    reset = 1'b1; master_clear = 1'b0; encoded_dma = 4'b0000; dma_request_state = 4'b0000;
    transfer_mode = 8'h00; transfer_type = 8'h00; dack_sense_active_high = 1'b0;
    terminal_count = 1'b0; end_of_process_n = 1'b1; ready = 1'b1; hold_acknowledge = 1'b0;
    test_reset();
    test_single_read();
    test_master_clear();
    test_block_write();
    test_demand();
    test_demand_eop();
    test_async_reset();
    test_wait_states();
    test_cascade();
    test_s0_abort();
    test_edge_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
